graphite_cmd_stream_tx: RTL and testbench
=========================================

// Module: graphite_cmd_stream_tx
// PURPOSE
//  Command-stream transmitter feeding the graphite rasterizer's AXI-stream command slave port.
//  Host/CPU side pushes 16-bit command words through a simple write strobe.
//  Words are buffered in a FIFO, then emitted in order as an AXI-stream master (tvalid/tready/tdata).
//  Decouples host bursts from rasterizer back-pressure; the rasterizer holds tready low during CLEAR.
// PARAMETERS
//  CMD_STREAM_WIDTH  16  width of a command word; must match the rasterizer's CMD_STREAM_WIDTH
//  FIFO_DEPTH        16  buffered words; power of two, >= 2
// PORTS
//  clk                 in   1                       single clock
//  reset_i             in   1                       synchronous, active-high reset
//  wr_i                in   1                       host write strobe, one word per cycle
//  wr_data_i           in   CMD_STREAM_WIDTH        command word: opcode at [OP_POS+:OP_SIZE], payload below
//  full_o              out  1                       level_o == FIFO_DEPTH
//  empty_o             out  1                       level_o == 0
//  level_o             out  $clog2(FIFO_DEPTH)+1    words accepted and not yet handed off
//  overflow_o          out  1                       sticky: a write was dropped because the FIFO was full
//  overflow_clr_i      in   1                       clears overflow_o
//  cmd_axis_tvalid_o   out  1                       AXI-stream master valid
//  cmd_axis_tready_i   in   1                       AXI-stream master ready (from the rasterizer)
//  cmd_axis_tdata_o    out  CMD_STREAM_WIDTH        AXI-stream master data
// BEHAVIOUR
//  Reset values:
//   - rd_ptr = wr_ptr = 0; level_o = 0; empty_o = 1; full_o = 0; overflow_o = 0; cmd_axis_tvalid_o = 0.
//   - cmd_axis_tdata_o is don't-care while tvalid_o = 0.
//  Storage and pointers:
//   - Storage mem[FIFO_DEPTH] with wr_ptr/rd_ptr, each $clog2(FIFO_DEPTH)+1 bits (extra wrap bit).
//   - Pointers wrap naturally modulo 2*FIFO_DEPTH.
//   - level_o = wr_ptr - rd_ptr (unsigned, same width); full when MSBs differ and low bits are equal.
//  Accept and handshake:
//   - Accept: wr_i && !full_o -> mem[wr_ptr[low]] <= wr_data_i; wr_ptr++.
//   - Handshake: cmd_axis_tvalid_o && cmd_axis_tready_i -> rd_ptr++.
//   - cmd_axis_tvalid_o = !empty_o, driven from registered pointers (no combinational path from wr_i or tready_i).
//   - cmd_axis_tdata_o = mem[rd_ptr[low]].
//  Latency and throughput:
//   - Word written at cycle N into an empty FIFO shows on tvalid/tdata at cycle N+1.
//   - Sustained rate is 1 word/cycle when tready_i = 1.
//  AXI rules:
//   - Once tvalid_o = 1, it stays high and tdata_o stays stable until the handshake. Reset is the only exception.
//   - The head slot is never overwritten while occupied.
//  Full:
//   - wr_i while full_o -> word dropped, pointers unchanged, overflow_o <= 1 next cycle.
//   - This holds even if a handshake frees a slot in the same cycle; full is evaluated on current state.
//  Empty:
//   - wr_i and tready_i in the same cycle while empty -> word accepted, no handshake (tvalid was 0).
//  Simultaneous accept + handshake: both pointers advance, level unchanged.
//  overflow_clr_i coinciding with a new drop -> set wins, overflow_o stays 1.
//  Reset mid-transfer:
//   - All buffered words are discarded; tvalid_o = 0 the next cycle regardless of tready_i.
//   - reset_i has priority over every other input in that cycle.
//  State machine:
//   - Implicit, two states: EMPTY (tvalid 0) and STREAMING (tvalid 1).
//   - EMPTY -> STREAMING on accept. STREAMING -> EMPTY on handshake when level_o == 1 and no accept that cycle.
//  Width: level_o never exceeds FIFO_DEPTH; no arithmetic beyond pointer increment and subtract.
// STRUCTURE
//  Package:
//   - Opcode constants OP_POS, OP_SIZE, OP_NOP and OP_CLEAR stay in graphite_pkg.sv.
//   - Add CMD_FIFO_DEPTH_DEFAULT = 16 to graphite_pkg.sv.
//  Single flat module, no sub-module. Storage is a plain register array (distributed RAM / LUTRAM).
// TESTING
//  Each scenario lists stimulus -> required response.
//  1. After reset -> tvalid_o=0, empty_o=1, level_o=0, overflow_o=0.
//  2. Single word, tready=1:
//     write {OP_CLEAR, 12'h0F0} at cycle N -> tvalid=1, tdata={OP_CLEAR,12'h0F0} at N+1; handshake at N+1; empty_o=1 at N+2.
//  3. Back-pressure:
//     tready=0, write 16 words 16'h0001..16'h0010 -> full_o=1, level_o=16, tdata=16'h0001 stable.
//     17th write -> overflow_o=1, level_o=16.
//     tready=1 -> exactly 16'h0001..16'h0010 emitted in order.
//  4. Streaming:
//     continuous writes + tready=1 for 100 cycles -> one handshake per cycle, level_o stays 1.
//     Output sequence equals input sequence.
//  5. Drop with concurrent handshake:
//     full, wr_i and handshake in the same cycle -> word dropped, overflow_o=1, level_o=15.
//     Same cycle as overflow_clr_i -> overflow_o stays 1.
//  6. Reset mid-stream:
//     level_o=5, tready=0, assert reset_i one cycle -> next cycle tvalid_o=0, level_o=0.
//     Then write 16'hABCD -> emitted as the first word.

Source files
------------

// File: rtl/graphite_pkg.sv
// Shared definitions for the graphite rasterizer command path.
//   OP_POS / OP_SIZE         : opcode field placement inside a command word
//   OP_NOP / OP_CLEAR        : opcode values understood by the rasterizer
//   CMD_FIFO_DEPTH_DEFAULT   : default buffering depth of the command transmitter
//   cmd_stream_state_t       : transmitter stream state (EMPTY / STREAMING)
package graphite_pkg;

    localparam int          OP_POS   = 12;
    localparam int          OP_SIZE  = 4;
    localparam logic [3:0]  OP_NOP   = 4'h0;
    localparam logic [3:0]  OP_CLEAR = 4'h1;

    localparam int          CMD_FIFO_DEPTH_DEFAULT = 16;

    // The transmitter's state is implicit in its pointers: STREAMING exactly
    // when tvalid is high, EMPTY otherwise.
    typedef enum logic {
        ST_EMPTY     = 1'b0,
        ST_STREAMING = 1'b1
    } cmd_stream_state_t;

endpackage

// File: rtl/graphite_cmd_stream_tx.sv
// Command-stream transmitter: host pushes command words with a write strobe,
// words are buffered in a FIFO and replayed in order on an AXI-stream master.
//
// Handshake: a word moves to the rasterizer on every rising clk edge where
// cmd_axis_tvalid_o && cmd_axis_tready_i. tvalid never depends on tready in
// the same cycle and, once high, holds with stable tdata until that handshake.
//
// Ports
//   clk                in   clock
//   reset_i            in   synchronous active-high reset, highest priority
//   wr_i / wr_data_i   in   host write strobe and command word
//   full_o / empty_o   out  FIFO full / empty flags
//   level_o            out  words accepted and not yet handed off
//   overflow_o         out  sticky: a write was dropped while full
//   overflow_clr_i     in   clears overflow_o (a same-cycle drop wins)
//   cmd_axis_*         AXI-stream master toward the rasterizer
module graphite_cmd_stream_tx
    import graphite_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = 16,
    parameter int FIFO_DEPTH       = CMD_FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          wr_i,
    input  logic [CMD_STREAM_WIDTH-1:0]   wr_data_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    input  logic                          overflow_clr_i,
    output logic                          cmd_axis_tvalid_o,
    input  logic                          cmd_axis_tready_i,
    output logic [CMD_STREAM_WIDTH-1:0]   cmd_axis_tdata_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [CMD_STREAM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        accept;
    logic                        handshake;

    // All flags come from the registered pointers only, so there is no
    // combinational path from wr_i or tready_i to tvalid/full/empty.
    assign level_o   = wr_ptr - rd_ptr;
    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign cmd_axis_tvalid_o = !empty_o;
    assign cmd_axis_tdata_o  = mem[rd_ptr[AW-1:0]];

    // Full is judged on the current state: a handshake freeing a slot this
    // cycle does not let a write in, which also keeps the head slot intact.
    assign accept    = wr_i && !full_o;
    assign handshake = cmd_axis_tvalid_o && cmd_axis_tready_i;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (handshake) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (wr_i && full_o) begin
                overflow_o <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    // Storage has no reset; contents are only visible behind valid pointers.
    always_ff @(posedge clk) begin
        if (!reset_i && accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_graphite_cmd_stream_tx.sv
module tb_graphite_cmd_stream_tx;
    import graphite_pkg::*;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int LW = $clog2(D) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          wr_i = 1'b0;
    logic [W-1:0]  wr_data_i = '0;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic          overflow_clr_i = 1'b0;
    logic          cmd_axis_tvalid_o;
    logic          cmd_axis_tready_i = 1'b0;
    logic [W-1:0]  cmd_axis_tdata_o;

    always #5 clk = ~clk;

    graphite_cmd_stream_tx #(
        .CMD_STREAM_WIDTH (W),
        .FIFO_DEPTH       (D)
    ) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .wr_i              (wr_i),
        .wr_data_i         (wr_data_i),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .level_o           (level_o),
        .overflow_o        (overflow_o),
        .overflow_clr_i    (overflow_clr_i),
        .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
        .cmd_axis_tready_i (cmd_axis_tready_i),
        .cmd_axis_tdata_o  (cmd_axis_tdata_o)
    );

    // ---------------- scoreboard / model ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           mlevel = 0;
    logic         movf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs: compare DUT outputs
    // against the model at the falling edge, then advance the model by what
    // the rising edge will do.
    task automatic step();
        logic acc;
        logic hs;
        logic drop;
        @(negedge clk);
        chk("tvalid",   32'(cmd_axis_tvalid_o), 32'(mlevel > 0));
        chk("level",    32'(level_o),           32'(mlevel));
        chk("full",     32'(full_o),            32'(mlevel == D));
        chk("empty",    32'(empty_o),           32'(mlevel == 0));
        chk("overflow", 32'(overflow_o),        32'(movf));
        if (mlevel > 0) chk("tdata_head", 32'(cmd_axis_tdata_o), 32'(exp_q[0]));
        if (reset_i) begin
            exp_q.delete();
            mlevel = 0;
            movf   = 1'b0;
        end else begin
            hs   = cmd_axis_tready_i && (mlevel > 0);
            acc  = wr_i && (mlevel < D);
            drop = wr_i && (mlevel == D);
            if (hs)  void'(exp_q.pop_front());
            if (acc) exp_q.push_back(wr_data_i);
            mlevel = mlevel + int'(acc) - int'(hs);
            if (drop)                movf = 1'b1;
            else if (overflow_clr_i) movf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        wr_i      = 1'b1;
        wr_data_i = d;
        step();
        wr_i      = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] d;

        // reset
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;

        // 1. reset state
        chk("rst_tvalid",   32'(cmd_axis_tvalid_o), 32'd0);
        chk("rst_empty",    32'(empty_o),           32'd1);
        chk("rst_level",    32'(level_o),           32'd0);
        chk("rst_overflow", 32'(overflow_o),        32'd0);
        step();

        // 2. single word with tready high: visible the cycle after the write
        cmd_axis_tready_i = 1'b1;
        d = {OP_CLEAR, 12'h0F0};
        write_word(d);
        chk("s2_tvalid", 32'(cmd_axis_tvalid_o), 32'd1);
        chk("s2_tdata",  32'(cmd_axis_tdata_o),  32'(d));
        step();
        chk("s2_empty",  32'(empty_o), 32'd1);
        step();

        // 3. back-pressure: fill, overflow, then drain in order
        cmd_axis_tready_i = 1'b0;
        for (int i = 1; i <= 16; i++) write_word(W'(i));
        chk("s3_full",  32'(full_o),  32'd1);
        chk("s3_level", 32'(level_o), 32'd16);
        chk("s3_head",  32'(cmd_axis_tdata_o), 32'h0001);
        write_word(16'h0011);
        chk("s3_overflow", 32'(overflow_o), 32'd1);
        chk("s3_level2",   32'(level_o),    32'd16);
        cmd_axis_tready_i = 1'b1;
        repeat (16) step();
        chk("s3_drained", 32'(empty_o), 32'd1);

        // 4. streaming: one word in, one word out per cycle
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        wr_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data_i = W'($urandom_range(0, 16'hFFFF));
            step();
        end
        chk("s4_level", 32'(level_o), 32'd1);
        wr_i = 1'b0;
        repeat (2) step();

        // 5. drop with concurrent handshake and concurrent clear
        cmd_axis_tready_i = 1'b0;
        for (int i = 0; i < 16; i++) write_word(W'(16'h0100 + i));
        wr_i = 1'b1;
        wr_data_i = 16'hBEEF;
        cmd_axis_tready_i = 1'b1;
        overflow_clr_i = 1'b1;
        step();
        wr_i = 1'b0;
        cmd_axis_tready_i = 1'b0;
        overflow_clr_i = 1'b0;
        chk("s5_level",    32'(level_o),    32'd15);
        chk("s5_overflow", 32'(overflow_o), 32'd1);
        step();
        cmd_axis_tready_i = 1'b1;
        repeat (15) step();
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        step();

        // 6. reset mid-stream
        cmd_axis_tready_i = 1'b0;
        for (int i = 0; i < 5; i++) write_word(W'(16'h0200 + i));
        chk("s6_level_pre", 32'(level_o), 32'd5);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("s6_tvalid", 32'(cmd_axis_tvalid_o), 32'd0);
        chk("s6_level",  32'(level_o),           32'd0);
        step();
        cmd_axis_tready_i = 1'b1;
        write_word(16'hABCD);
        chk("s6_first", 32'(cmd_axis_tdata_o), 32'hABCD);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
